// File: rtl/pb_debounce_pkg.sv
// -----------------------------------------------------------------------------
// pb_debounce_pkg
//   Shared constants and helpers for the multi-channel push-button conditioner.
//   - clog2(): number of bits needed to hold the values 0..value-1 (minimum 1).
//   - DEF_*:   default timing parameters (100 MHz clock, 2.5 ms filter tick).
//   - DEF_*_W: counter widths that match the default timing parameters.
// -----------------------------------------------------------------------------
package pb_debounce_pkg;

    localparam int DEF_TICK_DIV     = 250000;
    localparam int DEF_STABLE_TICKS = 4;
    localparam int DEF_LONG_TICKS   = 400;
    localparam int MAX_CH           = 32;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int DEF_TICK_W   = clog2(DEF_TICK_DIV);
    localparam int DEF_STABLE_W = clog2(DEF_STABLE_TICKS + 1);
    localparam int DEF_HOLD_W   = clog2(DEF_LONG_TICKS + 1);

endpackage

// File: rtl/pb_debounce_chan.sv
// -----------------------------------------------------------------------------
// pb_debounce_chan
//   One push-button channel: 2-FF synchroniser, tick-qualified stability
//   filter, registered press/release pulses and an optional long-press pulse.
// Ports
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   raw_i    in  raw asynchronous pin
//   tick_i   in  shared filter tick strobe (one clk wide)
//   level_o  out debounced pressed level (1 = pressed)
//   press_o  out one-clk pulse when a 0->1 level change is accepted
//   rel_o    out one-clk pulse when a 1->0 level change is accepted
//   long_o   out one-clk pulse once per press after LONG_TICKS held ticks
// -----------------------------------------------------------------------------
module pb_debounce_chan
    import pb_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o,
    output logic long_o
);

    localparam int               CNT_W    = clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // Synchroniser: idles at the un-pressed pin value so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ ACTIVE_LOW;

    // Filter: any cycle where the input agrees with the accepted level restarts
    // qualification, so a single glitch costs a full STABLE_TICKS window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                cnt_d   = '0;
                press_d = s;
                rel_d   = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;

    generate
        if (LONG_TICKS > 0) begin : g_long
            localparam int                HOLD_W   = clog2(LONG_TICKS + 1);
            localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

            logic [HOLD_W-1:0] hold_q, hold_d;
            logic              long_q, long_d;

            // Saturating at HOLD_MAX is what makes the pulse fire only once per press.
            always_comb begin
                hold_d = hold_q;
                long_d = 1'b0;
                if (!level_q) begin
                    hold_d = '0;
                end else if (tick_i && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                    long_d = (hold_d == HOLD_MAX);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                end
            end

            assign long_o = long_q;
        end else begin : g_no_long
            assign long_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pb_debounce_multi.sv
// -----------------------------------------------------------------------------
// pb_debounce_multi
//   N-channel push-button conditioner. One shared tick divider drives N_CH
//   independent pb_debounce_chan instances.
// Ports
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   pb_raw    in  [N_CH] raw asynchronous button pins
//   pb_level  out [N_CH] debounced pressed level (1 = pressed)
//   pb_press  out [N_CH] one-clk pulse on accepted press
//   pb_rel    out [N_CH] one-clk pulse on accepted release
//   pb_long   out [N_CH] one-clk pulse per press after LONG_TICKS held ticks
//   tick      out one-clk filter tick strobe, every TICK_DIV clocks
// -----------------------------------------------------------------------------
module pb_debounce_multi
    import pb_debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb_raw,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_press,
    output logic [N_CH-1:0] pb_rel,
    output logic [N_CH-1:0] pb_long,
    output logic            tick
);

    localparam int                TICK_W    = clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    // Tick is decoded from the counter so it is high exactly while count == TICK_DIV-1.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_chan
            pb_debounce_chan #(
                .STABLE_TICKS (STABLE_TICKS),
                .LONG_TICKS   (LONG_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .raw_i   (pb_raw[i]),
                .tick_i  (tick),
                .level_o (pb_level[i]),
                .press_o (pb_press[i]),
                .rel_o   (pb_rel[i]),
                .long_o  (pb_long[i])
            );
        end
    endgenerate

endmodule
